// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
//   IF_RESET_PC : default first fetch address after reset
//   EXC_ADEL    : ExcCode reported for a misaligned instruction fetch
//   entry_t     : one queue entry {instr, pc, exc}
//   clog2       : ceiling log2, used to size pointers and counters
package if_prefetch_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of the prefetch unit's handshake signals.
//   imem_*      : request/grant/response instruction-memory port
//   redirect*   : flush and restart request from NPC / CP0
//   out_*       : valid/ready instruction stream towards ID
// master = the prefetch unit, slave = memory + NPC/CP0 + ID side.
interface if_prefetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_exc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_pc, out_exc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_pc, out_exc,
        output out_ready
    );

endinterface

// File: rtl/if_prefetch_fetch_fifo.sv
// Synchronous FIFO with first-word fall-through head and flush.
//   clk, reset : clock, synchronous active-high reset (clears storage too)
//   flush      : empties the FIFO, has priority over push/pop
//   push/push_data, pop : write and remove-head strobes
//   head       : registered storage at the read pointer
//   count      : current occupancy, 0..DEPTH
module if_prefetch_fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && (count != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + ONE;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Decoupled instruction-fetch front end with a DEPTH-entry prefetch queue.
//   clk, reset : clock, synchronous active-high reset
//   bus        : if_prefetch_if.master
//                imem_req/addr out, imem_gnt/rvalid/rdata in,
//                redirect/redirect_pc in,
//                out_valid/instr/pc/exc out, out_ready in
// Fetches are credit limited: a request is only made while the queue plus
// the in-flight requests leave room, so every response has a slot waiting.
// A redirect turns all outstanding requests into drops and restarts fetch.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    if_prefetch_if.master bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    // Headroom for redirects that stack up before old responses drain.
    localparam int DW = CW + 2;
    localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);
    localparam logic [DW-1:0] DROP_ONE = DW'(1);

    logic [31:0]   fetch_pc;
    logic [DW-1:0] drop;
    logic          halt;
    logic [CW-1:0] occ;
    logic [CW-1:0] infl;
    logic [31:0]   infl_pc;
    entry_t        push_entry;
    entry_t        head_entry;

    logic space;
    logic misaligned;
    logic issue_ok;
    logic req;
    logic grant;
    logic rsp_counted;
    logic rsp_drop;
    logic rsp_take;
    logic exc_push;
    logic ent_push;
    logic ent_pop;

    always_comb begin
        space       = ({1'b0, occ} + {1'b0, infl}) < CAP;
        misaligned  = (fetch_pc[1:0] != 2'b00);
        issue_ok    = !reset && !halt && !bus.redirect && space;
        req         = issue_ok && !misaligned;
        grant       = req && bus.imem_gnt;
        // Responses arrive in order, so pending drops always come first.
        rsp_counted = bus.imem_rvalid && ((drop != '0) || (infl != '0));
        rsp_drop    = bus.imem_rvalid && (drop != '0);
        rsp_take    = bus.imem_rvalid && (drop == '0) && (infl != '0);
        // A misaligned PC only exists right after a redirect/reset, when
        // nothing is in flight, so it never competes with a real response.
        exc_push    = issue_ok && misaligned && !rsp_take;
        ent_push    = rsp_take || exc_push;
        ent_pop     = !reset && (occ != '0) && bus.out_ready && !bus.redirect;

        push_entry.instr = bus.imem_rdata;
        push_entry.pc    = infl_pc;
        push_entry.exc   = 1'b0;
        if (!rsp_take) begin
            push_entry.instr = '0;
            push_entry.pc    = fetch_pc;
            push_entry.exc   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
            halt     <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            halt     <= 1'b0;
            drop     <= drop + DW'(infl) + DW'(grant) - DW'(rsp_counted);
        end else begin
            if (grant)    fetch_pc <= fetch_pc + 32'd4;
            if (exc_push) halt     <= 1'b1;
            if (rsp_drop) drop     <= drop - DROP_ONE;
        end
    end

    if_prefetch_fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (ent_push),
        .push_data (push_entry),
        .pop       (ent_pop),
        .head      (head_entry),
        .count     (occ)
    );

    // PCs of granted-but-unanswered requests; its occupancy is the in-flight count.
    if_prefetch_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (rsp_take),
        .head      (infl_pc),
        .count     (infl)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = !reset && (occ != '0);
    assign bus.out_instr = head_entry.instr;
    assign bus.out_pc    = head_entry.pc;
    assign bus.out_exc   = head_entry.exc;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a fixed vector table for the basic
// stream and misaligned fetch, hand sequences for the multi-cycle cases and
// a randomized run against a queue-based reference model with epochs.
module tb_if_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_3000;

    logic clk;
    logic reset;
    if_prefetch_if bus ();

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_grant  = 0;

    typedef struct { logic [31:0] pc; int ep; int cyc; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic exc; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          m_ep;

    typedef struct {
        bit rst; bit gnt; bit rv; logic [31:0] rva; bit redir; logic [31:0] rpc; bit rdy;
        bit e_req; logic [31:0] e_addr; bit e_val; logic [31:0] e_pc; bit e_exc; bit zero;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input bit rst, gnt, rv, input logic [31:0] rva,
                                input bit redir, input logic [31:0] rpc, input bit rdy,
                                input bit e_req, input logic [31:0] e_addr, input bit e_val,
                                input logic [31:0] e_pc, input bit e_exc, input bit zero);
        vec_t v;
        v.rst = rst; v.gnt = gnt; v.rv = rv; v.rva = rva; v.redir = redir; v.rpc = rpc;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        v.e_exc = e_exc; v.zero = zero;
        return v;
    endfunction

    // One clock cycle driven against the reference model; memory responses
    // come from the pending-request queue when rv_en allows it.
    task automatic cycle(input bit rst, input bit g, input bit rv_en, input bit redir,
                         input logic [31:0] rpc, input bit rdy);
        bit   rv, exp_req, exp_val, space;
        int   live;
        req_t r;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        rv = !rst && rv_en && (pend.size() > 0) && (pend[0].cyc < cyc);
        reset           = rst;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? data_of(pend[0].pc) : $urandom;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        #3;
        live = 0;
        foreach (pend[i]) if (pend[i].ep == m_ep) live++;
        space   = (mq.size() + live) < DEPTH;
        exp_req = !rst && !m_halt && !redir && space && (m_pc[1:0] == 2'b00);
        exp_val = !rst && (mq.size() > 0);
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_val});
        if (exp_val) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_instr", bus.out_instr, mq[0].instr);
            chk("out_exc", {31'd0, bus.out_exc}, {31'd0, mq[0].exc});
        end
        if (rst) begin
            pend.delete();
            mq.delete();
            m_pc   = RPC;
            m_halt = 1'b0;
            m_ep++;
        end else begin
            if (rv) begin
                r = pend.pop_front();
                if (!redir && r.ep == m_ep) begin
                    e.instr = data_of(r.pc); e.pc = r.pc; e.exc = 1'b0;
                    mq.push_back(e);
                end
            end
            if (redir) begin
                mq.delete();
                m_ep++;
                m_pc   = rpc;
                m_halt = 1'b0;
            end else begin
                if (exp_val && rdy) begin
                    e = mq.pop_front();
                    pop_log.push_back(e.pc);
                end
                if (exp_req && g) begin
                    r.pc = m_pc; r.ep = m_ep; r.cyc = cyc;
                    pend.push_back(r);
                    m_pc = m_pc + 32'd4;
                    n_grant++;
                end else if (!m_halt && space && m_pc[1:0] != 2'b00) begin
                    e.instr = '0; e.pc = m_pc; e.exc = 1'b1;
                    mq.push_back(e);
                    m_halt = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
        m_pc = RPC; m_halt = 1'b0; m_ep = 0;

        //           rst gnt rv rva          rd rpc          rdy  req addr         val pc           exc zero
        tv.push_back(mk(1, 0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0, 0));
        tv.push_back(mk(1, 0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0, 1));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            1,   1, 32'h3000,     0, 0,            0, 0));
        tv.push_back(mk(0, 1, 1, 32'h3000,     0, 0,            1,   1, 32'h3004,     0, 0,            0, 0));
        tv.push_back(mk(0, 1, 1, 32'h3004,     0, 0,            1,   1, 32'h3008,     1, 32'h3000,     0, 0));
        tv.push_back(mk(0, 1, 1, 32'h3008,     0, 0,            1,   1, 32'h300C,     1, 32'h3004,     0, 0));
        tv.push_back(mk(0, 0, 1, 32'h300C,     0, 0,            1,   1, 32'h3010,     1, 32'h3008,     0, 0));
        tv.push_back(mk(0, 0, 0, 0,            0, 0,            1,   1, 32'h3010,     1, 32'h300C,     0, 0));
        tv.push_back(mk(0, 0, 0, 0,            0, 0,            1,   1, 32'h3010,     0, 0,            0, 0));
        tv.push_back(mk(0, 1, 0, 0,            1, 32'h3002,     1,   0, 0,            0, 0,            0, 0));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0, 0));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            1, 32'h3002,     1, 0));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            1,   0, 0,            1, 32'h3002,     1, 0));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0, 0));
        tv.push_back(mk(0, 1, 0, 0,            1, 32'h3000,     1,   0, 0,            0, 0,            0, 0));
        tv.push_back(mk(0, 1, 0, 0,            0, 0,            1,   1, 32'h3000,     0, 0,            0, 0));
        tv.push_back(mk(0, 0, 1, 32'h3000,     0, 0,            1,   1, 32'h3004,     0, 0,            0, 0));
        tv.push_back(mk(0, 0, 0, 0,            0, 0,            1,   1, 32'h3004,     1, 32'h3000,     0, 0));
        tv.push_back(mk(0, 0, 0, 0,            0, 0,            1,   1, 32'h3004,     0, 0,            0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            cyc             = i;
            reset           = tv[i].rst;
            bus.imem_gnt    = tv[i].gnt;
            bus.imem_rvalid = tv[i].rv;
            bus.imem_rdata  = data_of(tv[i].rva);
            bus.redirect    = tv[i].redir;
            bus.redirect_pc = tv[i].rpc;
            bus.out_ready   = tv[i].rdy;
            #3;
            chk("tv_req", {31'd0, bus.imem_req}, {31'd0, tv[i].e_req});
            if (tv[i].e_req) chk("tv_addr", bus.imem_addr, tv[i].e_addr);
            chk("tv_valid", {31'd0, bus.out_valid}, {31'd0, tv[i].e_val});
            if (tv[i].e_val) begin
                chk("tv_pc", bus.out_pc, tv[i].e_pc);
                chk("tv_exc", {31'd0, bus.out_exc}, {31'd0, tv[i].e_exc});
                chk("tv_instr", bus.out_instr, tv[i].e_exc ? 32'd0 : data_of(tv[i].e_pc));
            end
            if (tv[i].zero) begin
                chk("rst_pc", bus.out_pc, 32'd0);
                chk("rst_instr", bus.out_instr, 32'd0);
                chk("rst_exc", {31'd0, bus.out_exc}, 32'd0);
            end
        end
        cyc = 100;

        // ID stalled: exactly DEPTH grants, then release in order.
        cycle(1, 0, 0, 0, 0, 1);
        n_grant = 0;
        repeat (8) cycle(0, 1, 1, 0, 0, 0);
        chk("stall_grants", n_grant, 4);
        pop_log.delete();
        repeat (6) cycle(0, 1, 1, 0, 0, 1);
        chk("stall_release_cnt", {31'd0, pop_log.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < pop_log.size()) chk("stall_release_pc", pop_log[i], 32'h3000 + 32'(4 * i));
        chk("stall_resume", {31'd0, n_grant > 4}, 32'd1);

        // Three late responses, then redirect to 0x4180.
        cycle(1, 0, 0, 0, 0, 1);
        repeat (3) cycle(0, 1, 0, 0, 0, 1);
        repeat (5) cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 1, 32'h4180, 1);
        pop_log.delete();
        repeat (12) cycle(0, 1, 1, 0, 0, 1);
        chk("late_cnt", {31'd0, pop_log.size() >= 2}, 32'd1);
        if (pop_log.size() >= 2) begin
            chk("late_first_pc", pop_log[0], 32'h4180);
            chk("late_second_pc", pop_log[1], 32'h4184);
        end

        // Redirect in the same cycle as a response.
        cycle(1, 0, 0, 0, 0, 1);
        repeat (3) cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 1, 1, 32'h5000, 1);
        pop_log.delete();
        repeat (12) cycle(0, 1, 1, 0, 0, 1);
        chk("same_cyc_cnt", {31'd0, pop_log.size() >= 2}, 32'd1);
        if (pop_log.size() >= 2) begin
            chk("same_cyc_first", pop_log[0], 32'h5000);
            chk("same_cyc_second", pop_log[1], 32'h5004);
        end

        // Reset with two fetches in flight; the orphaned responses never come.
        cycle(1, 0, 0, 0, 0, 1);
        repeat (2) cycle(0, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        n_grant = 0;
        repeat (6) cycle(0, 1, 0, 0, 0, 1);
        chk("rst_infl_grants", n_grant, 4);
        pop_log.delete();
        repeat (8) cycle(0, 0, 1, 0, 0, 1);
        chk("rst_infl_pops", pop_log.size(), 4);
        if (pop_log.size() > 0) chk("rst_infl_first", pop_log[0], 32'h3000);

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3000; k++) begin
            bit          g, rv, rd, rdy;
            logic [31:0] rpc;
            g   = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 29) == 0) && (pend.size() <= DEPTH);
            rpc = 32'h0001_0000 + (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 3) != 0);
            cycle(0, g, rv, rd, rpc, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
